// File: rtl/interlaken_tx_metaframe_sched_if.sv
// Lane-side stream bundle for the Interlaken TX metaframe scheduler.
// Payload input from the striper and framed lane words out to the scrambler.
interface interlaken_tx_metaframe_sched_if;
    logic [64:0] din;
    logic        din_valid;
    logic        din_ready;
    logic [64:0] dout;
    logic        dout_valid;
    logic        dout_ready;
    logic        scram_bypass;
    logic        meta_start;

    modport master (
        input  din, din_valid, dout_ready,
        output din_ready, dout, dout_valid, scram_bypass, meta_start
    );

    modport slave (
        output din, din_valid, dout_ready,
        input  din_ready, dout, dout_valid, scram_bypass, meta_start
    );
endinterface

// File: rtl/interlaken_tx_metaframe_sched.sv
// Interlaken TX metaframe scheduler: sync, scrambler state, skip, payload, diag.
// Define TX_DIAG_CRC32_EN to fill diag[31:0] with a CRC-32C of the metaframe.
module interlaken_tx_metaframe_sched #(
    parameter int          META_FRAME_LEN = 10,
    parameter logic [63:0] IDLE_WORD      = 64'h0000_0000_0000_0000,
    parameter logic [63:0] SKIP_WORD      = 64'h1E1E_1E1E_1E1E_1E1E
) (
    input  logic        clk,
    input  logic        srst,
    input  logic        enable,
    input  logic [57:0] scram_state,
    input  logic        lane_status,
    input  logic        link_status,
    interlaken_tx_metaframe_sched_if.master lane
);
    localparam int          SW        = $clog2(META_FRAME_LEN);
    localparam logic [SW-1:0] LAST    = SW'(META_FRAME_LEN - 1);
    localparam logic [SW-1:0] PAY_LO  = SW'(3);
    localparam logic [63:0] SYNC_WORD = 64'h78F6_78F6_78F6_78F6;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN
    } state_t;

    state_t        state;
    logic [SW-1:0] slot;
    logic          load;
    logic          payload;
    logic          last;
    logic [64:0]   word_raw;
    logic [64:0]   word;
    logic [31:0]   crc_field;

    assign load    = (state != S_IDLE) &
                     (!lane.dout_valid | lane.dout_ready);
    assign last    = (slot == LAST);
    assign payload = (slot >= PAY_LO) && (slot < LAST);

    assign lane.din_ready = load & payload;

    always_comb begin
        word_raw = {1'b1, IDLE_WORD};
        unique case (1'b1)
            slot == '0:     word_raw = {1'b1, SYNC_WORD};
            slot == SW'(1): word_raw = {1'b1, 6'b001010, scram_state};
            slot == SW'(2): word_raw = {1'b1, SKIP_WORD};
            last: word_raw = {1'b1, 6'b011001, 24'h0,
                              lane_status, link_status, 32'h0};
            default: begin
                if (lane.din_valid) word_raw = lane.din;
            end
        endcase
    end

`ifdef TX_DIAG_CRC32_EN
    logic [31:0] crc_q;
    logic [31:0] crc_base;
    logic [31:0] crc_nxt;

    function automatic logic [31:0] crc32c_step(
        input logic [31:0] c,
        input logic [63:0] d
    );
        logic [31:0] r;
        r = c;
        for (int i = 63; i >= 0; i--) begin
            if (r[31] ^ d[i]) r = {r[30:0], 1'b0} ^ 32'h1EDC_6F41;
            else              r = {r[30:0], 1'b0};
        end
        return r;
    endfunction

    // Diag is folded in with its CRC field still zero, then complemented.
    assign crc_base  = (slot == '0) ? 32'hFFFF_FFFF : crc_q;
    assign crc_nxt   = crc32c_step(crc_base, word_raw[63:0]);
    assign crc_field = ~crc_nxt;

    always_ff @(posedge clk) begin
        if (srst)      crc_q <= 32'hFFFF_FFFF;
        else if (load) crc_q <= crc_nxt;
    end
`else
    assign crc_field = 32'h0;
`endif

    assign word = {word_raw[64:32], last ? crc_field : word_raw[31:0]};

    always_ff @(posedge clk) begin
        if (srst) begin
            lane.dout         <= '0;
            lane.dout_valid   <= 1'b0;
            lane.scram_bypass <= 1'b0;
            lane.meta_start   <= 1'b0;
            slot              <= '0;
            state             <= S_IDLE;
        end else begin
            if (load) begin
                lane.dout         <= word;
                lane.dout_valid   <= 1'b1;
                lane.scram_bypass <= (slot == '0) | (slot == SW'(1));
                lane.meta_start   <= (slot == '0);
                slot              <= last ? '0 : slot + SW'(1);
            end else if (lane.dout_ready) begin
                lane.dout_valid <= 1'b0;
            end

            unique case (state)
                S_IDLE: begin
                    if (enable) begin
                        state <= S_RUN;
                        slot  <= '0;
                    end
                end
                S_RUN: begin
                    if (!enable) state <= (load & last) ? S_IDLE : S_DRAIN;
                end
                S_DRAIN: begin
                    if (enable)           state <= S_RUN;
                    else if (load & last) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
